// File: rtl/cdb_arbiter.sv
// cdb_arbiter: common data bus arbiter, consumer end of the exu2cdb handshake.
// Collects completed results from NUM_EXU execution units and grants one per
// cycle. The winner is broadcast on the CDB as a registered one-cycle pulse.
//
// Configuration macro: CDB_FIXED_PRIO_EN
//   undefined (default): round-robin arbitration starting at rr_ptr.
//   defined            : fixed priority, lowest index wins; no rr_ptr register.
//
// Ports:
//   clk        core clock
//   rst        asynchronous active-high reset
//   flush      pipeline flush; suppresses the grant this cycle
//   exu_req    per-unit result valid
//   exu_rdy    per-unit grant, combinational, one-hot or zero
//   exu_tag    per-unit tag, unit i at [i*TAG_W +: TAG_W]
//   exu_wdata  per-unit result, unit i at [i*32 +: 32]
//   cdb_vld    broadcast valid (registered)
//   cdb_tag    broadcast tag (registered)
//   cdb_wdata  broadcast data (registered)
module cdb_arbiter #(
  parameter int unsigned NUM_EXU = 4,
  parameter int unsigned TAG_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [NUM_EXU-1:0]       exu_req,
  output logic [NUM_EXU-1:0]       exu_rdy,
  input  logic [NUM_EXU*TAG_W-1:0] exu_tag,
  input  logic [NUM_EXU*32-1:0]    exu_wdata,
  output logic                     cdb_vld,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [31:0]              cdb_wdata
);

  localparam int unsigned PtrW = $clog2(NUM_EXU);

  logic             gnt_vld;
  logic [PtrW-1:0]  gnt_idx;
  logic [PtrW-1:0]  cand;
  logic             cdb_vld_d, cdb_vld_q;
  logic [TAG_W-1:0] cdb_tag_d, cdb_tag_q;
  logic [31:0]      cdb_wdata_d, cdb_wdata_q;

`ifndef CDB_FIXED_PRIO_EN
  logic [PtrW-1:0]  rr_ptr_d, rr_ptr_q;
  logic [PtrW:0]    sum;
`endif

  // Grant search. Reset and flush both force a zero grant.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
`ifndef CDB_FIXED_PRIO_EN
    sum     = '0;
`endif
    if (!rst && !flush) begin
      for (int unsigned off = 0; off < NUM_EXU; off++) begin
`ifndef CDB_FIXED_PRIO_EN
        // One extra bit so non-power-of-2 NUM_EXU wraps without overflow.
        sum = {1'b0, rr_ptr_q} + (PtrW+1)'(off);
        if (sum >= (PtrW+1)'(NUM_EXU)) begin
          sum = sum - (PtrW+1)'(NUM_EXU);
        end
        cand = sum[PtrW-1:0];
`else
        cand = PtrW'(off);
`endif
        if (!gnt_vld && exu_req[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  always_comb begin
    exu_rdy     = '0;
    cdb_vld_d   = gnt_vld;
    cdb_tag_d   = '0;
    cdb_wdata_d = '0;
    for (int unsigned i = 0; i < NUM_EXU; i++) begin
      if (gnt_vld && gnt_idx == PtrW'(i)) begin
        exu_rdy[i]  = 1'b1;
        cdb_tag_d   = exu_tag[i*TAG_W +: TAG_W];
        cdb_wdata_d = exu_wdata[i*32 +: 32];
      end
    end
  end

`ifndef CDB_FIXED_PRIO_EN
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_vld) begin
      rr_ptr_d = (gnt_idx == PtrW'(NUM_EXU - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  // Non-granting cycles load zeros, so the bus is cleared rather than held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_vld_q   <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_wdata_q <= '0;
    end else begin
      cdb_vld_q   <= cdb_vld_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_wdata_q <= cdb_wdata_d;
    end
  end

  assign cdb_vld   = cdb_vld_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_wdata = cdb_wdata_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(exu_rdy)) else $error("exu_rdy not onehot0");
      assert ((exu_rdy & ~exu_req) == '0) else $error("exu_rdy without exu_req");
      if (cdb_vld) begin
        assert (!$isunknown({cdb_tag, cdb_wdata})) else $error("X on cdb outputs");
      end
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int TW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [N-1:0]    exu_req;
  logic [N-1:0]    exu_rdy;
  logic [N*TW-1:0] exu_tag;
  logic [N*32-1:0] exu_wdata;
  logic            cdb_vld;
  logic [TW-1:0]   cdb_tag;
  logic [31:0]     cdb_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: next unit to be favoured, plus the expected bus contents.
  int          m_ptr;
  logic        m_vld;
  logic [TW-1:0] m_tag;
  logic [31:0] m_data;

  cdb_arbiter #(.NUM_EXU(N), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .exu_req   (exu_req),
    .exu_rdy   (exu_rdy),
    .exu_tag   (exu_tag),
    .exu_wdata (exu_wdata),
    .cdb_vld   (cdb_vld),
    .cdb_tag   (cdb_tag),
    .cdb_wdata (cdb_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Winner among requesters, scanning from the favoured unit; -1 if none.
  function automatic int model_grant();
    int start;
`ifdef CDB_FIXED_PRIO_EN
    start = 0;
`else
    start = m_ptr;
`endif
    if (rst || flush) return -1;
    for (int k = 0; k < N; k++) begin
      if (exu_req[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  // One cycle: inputs already driven; check at negedge, advance model at posedge.
  task automatic cycle();
    int g;
    @(negedge clk);
    g = model_grant();
    check("rdy", exu_rdy, onehot(g));
    check("cdb_vld", cdb_vld, m_vld);
    check("cdb_tag", cdb_tag, m_tag);
    check("cdb_wdata", cdb_wdata, m_data);
    @(posedge clk);
    if (g >= 0) begin
      m_ptr  = (g + 1) % N;
      m_vld  = 1'b1;
      m_tag  = exu_tag[g*TW +: TW];
      m_data = exu_wdata[g*32 +: 32];
    end else begin
      m_vld  = 1'b0;
      m_tag  = '0;
      m_data = '0;
    end
    #1;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_vld = 1'b0; m_tag = '0; m_data = '0;
  endtask

  task automatic set_unit(input int u, input logic [TW-1:0] t, input logic [31:0] d);
    exu_tag[u*TW +: TW] = t;
    exu_wdata[u*32 +: 32] = d;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; exu_req = '0; exu_tag = '0; exu_wdata = '0;
    model_reset();
    for (int u = 0; u < N; u++) set_unit(u, TW'(u + 8), 32'h1000_0000 + 32'(u));
    exu_req = '1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", exu_rdy, '0);
    check("rst_vld", cdb_vld, 1'b0);
    rst = 1'b0;
    exu_req = '0;

    // Single requester: unit 2, tag 3, 0xDEADBEEF.
    set_unit(2, 4'd3, 32'hDEAD_BEEF);
    exu_req = 4'b0100;
    #3 check("single_rdy", exu_rdy, 4'b0100);
    cycle();
    exu_req = '0;
    check("single_vld", cdb_vld, 1'b1);
    check("single_data", cdb_wdata, 32'hDEAD_BEEF);
    cycle();
    cycle();

    // Contention: all units held; rotates through every unit.
    exu_req = '1;
    repeat (6) cycle();

    // Wrap/skip: steer pointer to 3, then req=0110.
    exu_req = 4'b0100;
    cycle();
    exu_req = 4'b0110;
    #3 check("wrap_rdy1", exu_rdy, 4'b0010);
    cycle();
    #3 check("wrap_rdy2", exu_rdy, 4'b0100);
    cycle();

    // Flush with all requests high.
    exu_req = '1;
    flush = 1'b1;
    #3 check("flush_rdy", exu_rdy, '0);
    cycle();
    flush = 1'b0;
    repeat (3) cycle();

    // Fixed-priority style pattern (also valid round-robin stimulus).
    exu_req = 4'b1011;
    repeat (3) cycle();
    exu_req = 4'b1010;
    repeat (2) cycle();

    // Async reset while a broadcast with tag 5 is on the bus.
    set_unit(1, 4'd5, 32'hCAFE_0005);
    exu_req = 4'b0010;
    flush = 1'b0;
    model_reset();
    rst = 1'b1; #2 rst = 1'b0;
    cycle();
    exu_req = '0;
    check("pre_rst_vld", cdb_vld, 1'b1);
    check("pre_rst_tag", cdb_tag, 4'd5);
    #1 rst = 1'b1;
    #1;
    check("async_vld", cdb_vld, 1'b0);
    check("async_tag", cdb_tag, '0);
    check("async_data", cdb_wdata, '0);
    check("async_rdy", exu_rdy, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    exu_req = '1;
    #3 check("post_rst_rdy", exu_rdy, 4'b0001);
    cycle();

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      exu_req   = N'($urandom);
      flush     = ($urandom_range(0, 7) == 0);
      exu_tag   = (N*TW)'($urandom);
      exu_wdata = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end
    flush = 1'b0;
    exu_req = '0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
